// File: rtl/dbus_responder.sv
// Fixed-latency, word-addressed data-bus responder used as the data-memory backend.
// One request in flight at a time; illegal accesses still complete and raise a sticky error.
//
// state | meaning
// IDLE  | waiting for req_valid; request fields latched on acceptance
// WAIT  | counting down the remaining latency
// RESP  | one-cycle addr_ok/data_ok pulse; write committed when leaving
module dbus_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 2,
    parameter logic [63:0] BASE_ADDR  = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic [63:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [7:0]  req_strobe,
    input  logic [63:0] req_data,
    output logic        resp_addr_ok,
    output logic        resp_data_ok,
    output logic [63:0] resp_data,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t state, state_nxt;
    logic [3:0]  cnt;
    logic [63:0] lat_addr;
    logic [2:0]  lat_size;
    logic [7:0]  lat_strobe;
    logic [63:0] lat_data;

    logic [63:0] mem [(2**DEPTH_LOG2)];

    logic [63:0]           off;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  in_range;
    logic                  aligned;
    logic                  legal;
    logic                  wr_en;
    logic                  unused_off_lsb;

    // Offset wraps for addresses below BASE_ADDR, so one range test catches both sides.
    assign off            = lat_addr - BASE_ADDR;
    assign idx            = off[DEPTH_LOG2+2:3];
    assign in_range       = (off[63:DEPTH_LOG2+3] == '0);
    assign unused_off_lsb = ^off[2:0];

    always_comb begin
        aligned = 1'b0;
        case (lat_size)
            3'd0:    aligned = 1'b1;
            3'd1:    aligned = ~lat_addr[0];
            3'd2:    aligned = (lat_addr[1:0] == 2'b00);
            3'd3:    aligned = (lat_addr[2:0] == 3'b000);
            default: aligned = 1'b0;
        endcase
    end

    assign legal = in_range & aligned;
    assign wr_en = (state == RESP) && legal && (lat_strobe != 8'h00);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = (LATENCY > 1) ? WAIT : RESP;
            WAIT:    if (cnt == 4'd1) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            lat_addr   <= '0;
            lat_size   <= '0;
            lat_strobe <= '0;
            lat_data   <= '0;
            err        <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_addr   <= req_addr;
                        lat_size   <= req_size;
                        lat_strobe <= req_strobe;
                        lat_data   <= req_data;
                        cnt        <= 4'(LATENCY - 1);
                    end
                end
                WAIT:    cnt <= cnt - 4'd1;
                RESP:    if (!legal) err <= 1'b1;
                default: ;
            endcase
        end
    end

    // Storage is never reset; contents survive reset_n.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (lat_strobe[b]) mem[idx][8*b +: 8] <= lat_data[8*b +: 8];
            end
        end
    end

    assign resp_addr_ok = (state == RESP);
    assign resp_data_ok = (state == RESP);
    assign resp_data    = (state == RESP && legal) ? mem[idx] : '0;

endmodule

// File: tb/tb_dbus_responder.sv
// Directed and randomized bench for dbus_responder against a word-array reference model.
module tb_dbus_responder;

    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic [63:0] req_addr;
    logic [2:0]  req_size;
    logic [7:0]  req_strobe;
    logic [63:0] req_data;
    logic        aok, dok, err;
    logic [63:0] rdata;
    logic        aok2, dok2, err2;
    logic [63:0] rdata2;

    int checks = 0;
    int errors = 0;

    logic [63:0] mm [0:1023];
    bit          mdl_err;

    dbus_responder #(.DEPTH_LOG2(10), .LATENCY(LAT), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_size(req_size), .req_strobe(req_strobe), .req_data(req_data),
        .resp_addr_ok(aok), .resp_data_ok(dok), .resp_data(rdata), .err(err)
    );

    dbus_responder #(.DEPTH_LOG2(10), .LATENCY(1), .BASE_ADDR(BASE)) dut_l1 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_size(req_size), .req_strobe(req_strobe), .req_data(req_data),
        .resp_addr_ok(aok2), .resp_data_ok(dok2), .resp_data(rdata2), .err(err2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_legal(input logic [63:0] a, input logic [2:0] sz);
        logic [63:0] o;
        o = a - BASE;
        return (o < 64'd8192) && (sz <= 3'd3) && ((a % (64'd1 << sz)) == 64'd0);
    endfunction

    // One complete transaction; tog scrambles req_* during the first wait cycle.
    task automatic xact(input logic [63:0] a, input logic [2:0] sz, input logic [7:0] st,
                        input logic [63:0] d, input bit tog, input bit chk_data);
        logic [63:0] exp_d, got, mask;
        bit          lg;
        int          lat;
        int          w;
        lg    = m_legal(a, sz);
        w     = lg ? int'((a - BASE) >> 3) : 0;
        exp_d = lg ? mm[w] : 64'd0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = a; req_size = sz; req_strobe = st; req_data = d;
        @(posedge clk);
        lat = 0;
        got = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (tog && i == 1) begin
                req_addr = a ^ 64'h18; req_data = ~d; req_strobe = ~st; req_size = 3'd5;
            end
            if (dok === 1'b1) begin
                lat = i;
                got = rdata;
                chk("addr_ok_with_data_ok", {63'd0, aok}, 64'd1);
                break;
            end
        end
        chk("latency", 64'(lat), 64'(LAT));
        if (chk_data) chk("resp_data", got, exp_d);
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (lg && st != 8'h00) begin
            for (int b = 0; b < 8; b++) mask[8*b +: 8] = {8{st[b]}};
            mm[w] = (mm[w] & ~mask) | (d & mask);
        end
        if (!lg) mdl_err = 1'b1;
        @(negedge clk);
        chk("data_ok_one_cycle", {63'd0, dok}, 64'd0);
        chk("err", {63'd0, err}, {63'd0, mdl_err});
    endtask

    initial begin
        logic [63:0] a, d;
        logic [2:0]  sz;
        logic [7:0]  st;
        int          kind, idx, ob;

        reset_n = 1'b1; req_valid = 1'b0; req_addr = '0; req_size = '0;
        req_strobe = '0; req_data = '0; mdl_err = 1'b0;
        #2 reset_n = 1'b0;
        #3;
        chk("rst_addr_ok", {63'd0, aok}, 64'd0);
        chk("rst_data_ok", {63'd0, dok}, 64'd0);
        chk("rst_resp_data", rdata, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        @(posedge clk); #1 reset_n = 1'b1;

        // Preload a small working region through the bus.
        for (int i = 0; i < 16; i++) begin
            if (i == 0)      d = 64'h1122334455667788;
            else if (i == 1) d = 64'h0;
            else             d = {$urandom, $urandom};
            xact(BASE + 64'(i) * 8, 3'd3, 8'hFF, d, 1'b0, 1'b0);
        end

        xact(BASE, 3'd3, 8'h00, 64'd0, 1'b0, 1'b1);
        xact(BASE + 8, 3'd3, 8'h0F, 64'hAAAAAAAA_DEADBEEF, 1'b0, 1'b1);
        xact(BASE + 8, 3'd3, 8'h00, 64'd0, 1'b0, 1'b1);
        chk("merged_store", mm[1], 64'h00000000_DEADBEEF);

        xact(BASE - 8, 3'd3, 8'h00, 64'd0, 1'b0, 1'b1);
        xact(BASE + 2, 3'd2, 8'h3C, 64'hCAFEF00D_12345678, 1'b0, 1'b1);
        xact(BASE, 3'd3, 8'h00, 64'd0, 1'b0, 1'b1);

        // Reset in the middle of a store's wait phase.
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = BASE + 16; req_size = 3'd3;
        req_strobe = 8'hFF; req_data = '1;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        mdl_err = 1'b0;
        chk("midwait_rst_data_ok", {63'd0, dok}, 64'd0);
        chk("midwait_rst_addr_ok", {63'd0, aok}, 64'd0);
        chk("midwait_rst_resp_data", rdata, 64'd0);
        chk("midwait_rst_err", {63'd0, err}, 64'd0);
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("after_rst_no_pulse", {63'd0, dok}, 64'd0);
        end
        xact(BASE + 16, 3'd3, 8'h00, 64'd0, 1'b0, 1'b1);

        // Inputs scrambled while waiting: only the accepted values matter.
        xact(BASE + 24, 3'd3, 8'hF0, 64'h0123456789ABCDEF, 1'b1, 1'b1);
        xact(BASE + 24, 3'd3, 8'h00, 64'd0, 1'b0, 1'b1);
        xact(BASE, 3'd3, 8'h00, 64'd0, 1'b0, 1'b1);

        // Back-to-back on the single-cycle-latency instance.
        repeat (4) @(posedge clk);
        #1;
        req_valid = 1'b1; req_addr = BASE; req_size = 3'd3; req_strobe = 8'h00; req_data = '0;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_c1_data_ok", {63'd0, dok2}, 64'd1);
        chk("b2b_c1_addr_ok", {63'd0, aok2}, 64'd1);
        @(negedge clk);
        chk("b2b_c2_data_ok", {63'd0, dok2}, 64'd0);
        chk("b2b_c2_resp_data", rdata2, 64'd0);
        @(negedge clk);
        chk("b2b_c3_data_ok", {63'd0, dok2}, 64'd1);
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_c4_data_ok", {63'd0, dok2}, 64'd0);
        @(negedge clk);
        chk("b2b_c5_data_ok", {63'd0, dok2}, 64'd0);
        repeat (6) @(posedge clk);

        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 9));
            sz   = 3'($urandom_range(0, 3));
            idx  = int'($urandom_range(0, 15));
            ob   = int'($urandom_range(0, 7));
            a    = BASE + 64'(idx) * 8 + 64'((ob >> sz) << sz);
            if (kind == 7) begin
                sz = 3'($urandom_range(1, 3));
                a  = BASE + 64'(idx) * 8 + 64'd1;
            end else if (kind == 8) begin
                a = BASE + 64'd8192 + 64'(idx) * 8;
            end else if (kind == 9) begin
                sz = 3'($urandom_range(4, 7));
            end
            st = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
            d  = {$urandom, $urandom};
            xact(a, sz, st, d, 1'b0, 1'b1);
        end

        for (int i = 0; i < 16; i++) xact(BASE + 64'(i) * 8, 3'd3, 8'h00, 64'd0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
